// File: rtl/reg_write_arb.sv
// rtl/reg_write_arb.sv - round-robin arbiter for the shared register write port
// Optional LOCK_LIMIT_EN: caps a locked burst at MAX_LOCK consecutive grant cycles.
module reg_write_arb #(
  parameter int WIDTH    = 16,
  parameter int NREQ     = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      reg_D,
  output logic                  write,
  output logic                  busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LW-1:0]   last_winner;
  logic [LW-1:0]   next_winner;
  logic [LW-1:0]   idx;
  logic [NREQ-1:0] next_grant;
  logic            hold;
  logic            found;
  logic            lock_ok;

`ifdef LOCK_LIMIT_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt;

  assign lock_ok = (lock_cnt < CW'(MAX_LOCK));

  always_ff @(posedge CLK) begin
    if (reset) begin
      lock_cnt <= '0;
    end else if (hold) begin
      lock_cnt <= lock_cnt + 1'b1;
    end else if (|next_grant) begin
      lock_cnt <= CW'(1);
    end else begin
      lock_cnt <= '0;
    end
  end
`else
  assign lock_ok = 1'b1;
`endif

  // grant is one-hot at last_winner whenever it is non-zero
  assign hold = grant[last_winner] & req[last_winner] & lock[last_winner] & lock_ok;

  always_comb begin
    next_grant  = '0;
    next_winner = last_winner;
    found       = 1'b0;
    idx         = '0;
    if (hold) begin
      next_grant = grant;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        idx = LW'((int'(last_winner) + off) % NREQ);
        if (!found && req[idx]) begin
          found           = 1'b1;
          next_winner     = idx;
          next_grant[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      grant       <= '0;
      last_winner <= LW'(NREQ - 1);
    end else begin
      grant <= next_grant;
      if (|next_grant) begin
        last_winner <= next_winner;
      end
    end
  end

  always_comb begin
    reg_D = '0;
    for (int i = 0; i < NREQ; i++) begin
      reg_D = reg_D | (data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // a grant slot whose requester withdrew is simply lost
  assign write = (|(grant & req)) & ~reset;
  assign busy  = |grant;

endmodule

// File: tb/tb_reg_write_arb.sv
// tb/tb_reg_write_arb.sv - scoreboard bench for reg_write_arb
module tb_reg_write_arb;

  typedef struct {
    logic [3:0]  g;
    logic        w;
    logic [15:0] d;
    logic [15:0] q;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [63:0] data;
  logic [3:0]  grant;
  logic [15:0] reg_D;
  logic        write;
  logic        busy;
  logic [15:0] q_reg = 16'h0000;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  reg_write_arb #(.WIDTH(16), .NREQ(4), .MAX_LOCK(3)) dut (
    .CLK   (CLK),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .data  (data),
    .grant (grant),
    .reg_D (reg_D),
    .write (write),
    .busy  (busy)
  );

  always #5 CLK = ~CLK;

  // stand-in for the downstream 16-bit register
  always @(posedge CLK) begin
    if (write) q_reg <= reg_D;
  end

  task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] l,
                      input logic [3:0] eg, input logic ew, input logic [15:0] ed,
                      input logic [15:0] eq);
    exp_t e;
    @(posedge CLK);
    #1;
    reset = rst;
    req   = r;
    lock  = l;
    e.g = eg; e.w = ew; e.d = ed; e.q = eq; e.cyc = cyc;
    exp_q.push_back(e);
    cyc++;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 5;
      if (grant !== e.g) begin
        errors++;
        $display("FAIL grant c%0d: got %b want %b", e.cyc, grant, e.g);
      end
      if (write !== e.w) begin
        errors++;
        $display("FAIL write c%0d: got %b want %b", e.cyc, write, e.w);
      end
      if (reg_D !== e.d) begin
        errors++;
        $display("FAIL reg_D c%0d: got %h want %h", e.cyc, reg_D, e.d);
      end
      if (busy !== (|e.g)) begin
        errors++;
        $display("FAIL busy c%0d: got %b want %b", e.cyc, busy, |e.g);
      end
      if (q_reg !== e.q) begin
        errors++;
        $display("FAIL q c%0d: got %h want %h", e.cyc, q_reg, e.q);
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    lock  = 4'b0000;
    data  = {16'h4444, 16'h0045, 16'h2222, 16'h01A4};

    // reset with all requesting, then round robin
    step(1, 4'b1111, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0000);
    step(1, 4'b1111, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0000);
    step(0, 4'b1111, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0000);
    step(0, 4'b1111, 4'b0000, 4'b0001, 1, 16'h01A4, 16'h0000);
    step(0, 4'b1111, 4'b0000, 4'b0010, 1, 16'h2222, 16'h01A4);
    step(0, 4'b1111, 4'b0000, 4'b0100, 1, 16'h0045, 16'h2222);
    step(0, 4'b1111, 4'b0000, 4'b1000, 1, 16'h4444, 16'h0045);
    step(0, 4'b0000, 4'b0000, 4'b0001, 0, 16'h01A4, 16'h4444);
    step(0, 4'b0000, 4'b0000, 4'b0000, 0, 16'h0000, 16'h4444);

    // single write from requester 2, then a re-grant it no longer wants
    step(0, 4'b0100, 4'b0000, 4'b0000, 0, 16'h0000, 16'h4444);
    step(0, 4'b0100, 4'b0000, 4'b0100, 1, 16'h0045, 16'h4444);
    step(0, 4'b0000, 4'b0000, 4'b0100, 0, 16'h0045, 16'h0045);
    step(0, 4'b0000, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0045);

    // park last_winner at 3, then a locked burst from requester 1
    step(0, 4'b1000, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0045);
    step(0, 4'b1000, 4'b0000, 4'b1000, 1, 16'h4444, 16'h0045);
    step(0, 4'b1010, 4'b0010, 4'b1000, 1, 16'h4444, 16'h4444);
    step(0, 4'b1010, 4'b0010, 4'b0010, 1, 16'h2222, 16'h4444);
    step(0, 4'b1010, 4'b0010, 4'b0010, 1, 16'h2222, 16'h2222);
    step(0, 4'b1010, 4'b0010, 4'b0010, 1, 16'h2222, 16'h2222);
`ifdef LOCK_LIMIT_EN
    step(0, 4'b1010, 4'b0010, 4'b1000, 1, 16'h4444, 16'h2222);
    step(0, 4'b1010, 4'b0000, 4'b0010, 1, 16'h2222, 16'h4444);
`else
    step(0, 4'b1010, 4'b0010, 4'b0010, 1, 16'h2222, 16'h2222);
    step(0, 4'b1010, 4'b0000, 4'b0010, 1, 16'h2222, 16'h2222);
`endif
    step(0, 4'b1000, 4'b0000, 4'b1000, 1, 16'h4444, 16'h2222);
    step(0, 4'b0000, 4'b0000, 4'b1000, 0, 16'h4444, 16'h4444);

    // withdraw: requester 0 drops req in its grant cycle
    step(0, 4'b0001, 4'b0000, 4'b0000, 0, 16'h0000, 16'h4444);
    step(0, 4'b0000, 4'b0000, 4'b0001, 0, 16'h01A4, 16'h4444);
    step(0, 4'b0000, 4'b0000, 4'b0000, 0, 16'h0000, 16'h4444);

    // reset in the middle of a locked burst
    step(0, 4'b0100, 4'b0100, 4'b0000, 0, 16'h0000, 16'h4444);
    step(0, 4'b0100, 4'b0100, 4'b0100, 1, 16'h0045, 16'h4444);
    step(0, 4'b0100, 4'b0100, 4'b0100, 1, 16'h0045, 16'h0045);
    step(1, 4'b0100, 4'b0100, 4'b0100, 0, 16'h0045, 16'h0045);
    step(0, 4'b0100, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0045);
    step(0, 4'b0100, 4'b0000, 4'b0100, 1, 16'h0045, 16'h0045);
    step(0, 4'b0000, 4'b0000, 4'b0100, 0, 16'h0045, 16'h0045);
    step(0, 4'b0000, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0045);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_write_arb.md
Name: reg_write_arb

Overview:
- Round-robin arbiter sharing the single write port of one 16-bit register (reg_16b D/write) among NREQ requesters, e.g. ALU writeback, memory load, immediate load.
- Grant is registered, one-hot, with a per-requester lock for multi-cycle bursts.
- Sits between the datapath sources and the register. Drives that register's D and write inputs directly.

Parameters:
- WIDTH, 16, data width of the shared register port.
- NREQ, 4, number of requesters (2..8).
- MAX_LOCK, 8, maximum consecutive grant cycles under lock (used only with LOCK_LIMIT_EN).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; bit i = requester i.
- lock  input  NREQ  hold grant while asserted together with req.
- data  input  NREQ*WIDTH  flattened write data; requester i at bits [i*WIDTH +: WIDTH].
- grant  output  NREQ  registered one-hot grant; all-zero when idle.
- reg_D  output  WIDTH  write data to register D; mux of data by grant.
- write  output  1  write enable to register.
- busy  output  1  high when any grant bit is set.

Behaviour:
- Reset (synchronous, active-high; sampled on CLK edge):
  - Values after the edge: grant=0, busy=0, last_winner=NREQ-1, so requester 0 is first priority.
  - write is gated by ~reset combinationally, so no write occurs in any cycle where reset=1. This holds even if grant is still set.
- Arbitration is evaluated every cycle. Next grant is chosen as follows:
  - If the current winner w has grant[w] & req[w] & lock[w], grant stays at w (locked hold).
  - Otherwise, if req is non-zero, grant goes to the first requester with req set, searching w+1, w+2, … modulo NREQ. The search starts after last_winner when idle.
  - Otherwise grant=0.
- last_winner updates to the new winner on every edge where a new grant is issued.
- Latency: req seen at edge k gives grant at edge k+1. There is no bubble between back-to-back grants to different requesters.
- Unlocked grant lasts exactly one cycle. A requester holding req continuously without lock gets at most one cycle per NREQ cycles when all are requesting.
- write = |(grant & req) & ~reset (combinational).
  - If the granted requester drops req during its grant cycle, write=0 that cycle.
  - The grant slot is lost; there is no retry.
- reg_D = data slice selected by grant (combinational AND-OR mux). reg_D=0 when grant=0.
- Requester contract:
  - data[i] must be stable while grant[i]=1.
  - The register captures it on the edge ending that cycle.
- lock without req is ignored. lock asserted by a non-granted requester has no effect on arbitration order.
- A single requester with continuous req and no other requests is granted every cycle.
- busy = |grant.

Optional Feature:
- Macro LOCK_LIMIT_EN.
- Defined:
  - A lock counter counts consecutive locked-hold cycles.
  - After MAX_LOCK grant cycles to the same winner, the lock is ignored for one arbitration and round-robin advances. If no other req is pending, the same requester may be re-granted and the counter restarts.
  - The counter clears on reset and on any winner change.
- Undefined: lock is honoured indefinitely; no counter logic is synthesised.

Test Plan:
- Reset: assert reset 2 cycles with req=4'b1111 -> grant=0, write=0, busy=0; after release, first grant=4'b0001.
- Single write: req=4'b0100, data[2]=16'h0045 for one grant cycle -> grant=4'b0100 one edge later, write=1, reg_D=16'h0045; register Q=16'h0045 next edge.
- Round robin: req=4'b1111 held, lock=0 -> grant sequence 0001,0010,0100,1000,0001 on consecutive cycles; write=1 every cycle.
- Lock burst: req[1]=1, lock[1]=1 for 5 cycles, req[3]=1 throughout -> grant=0010 for 5 cycles, then 1000. With LOCK_LIMIT_EN and MAX_LOCK=3: grant=0010 for 3 cycles, then 1000.
- Withdraw: grant=0001 issued, req[0] dropped that cycle, data[0]=16'h01A4 -> write=0, Q unchanged.
- Reset mid-burst: locked grant=0100, reset=1 for 1 cycle -> write=0 that cycle, grant=0 next; after release with req=4'b0100, grant=0100 again.
